resp_arbiter: RTL
=================

RESP_ARBITER -- requirements
Module: resp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of response requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 16'd50000, cycles allowed in WAIT before abort, 16 bits, minimum 2.
REQ-003 Port clk, input, 1, sole clock, rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port req, input, NUM_REQ, per-requester level request; held until the matching gnt bit.
REQ-006 Port req_data, input, 8*NUM_REQ, byte i at bits [8i+7:8i]; stable while req[i]=1.
REQ-007 Port gnt, output, NUM_REQ, one-hot one-cycle pulse: byte accepted.
REQ-008 Port trmt, output, 1, one-cycle transmit strobe to the UART wrapper.
REQ-009 Port resp, output, 8, byte to the UART wrapper; registered.
REQ-010 Port tx_done, input, 1, UART transmit-complete level; may still be high from the prior byte.
REQ-011 Port busy, output, 1, high in SEND and WAIT.
REQ-012 Port timeout, output, 1, one-cycle pulse on WAIT abort.

Function
REQ-013 FSM states: IDLE, SEND, WAIT; encoding free.
REQ-014 IDLE, req=0: remain IDLE; trmt=gnt=0.
REQ-015 IDLE, req!=0: winner w = first set bit scanning upward from ptr+1, wrapping NUM_REQ-1 to 0; at that edge resp<=req_data[w], ptr<=w, go SEND.
REQ-016 SEND lasts exactly one cycle; trmt=1 and gnt[w]=1 during it; then WAIT.
REQ-017 Latency: req sampled high at edge k -> trmt/gnt high in cycle k+1.
REQ-018 tx_done is ignored during SEND (stale-done guard).
REQ-019 WAIT, tx_done=1: go IDLE at next edge.
REQ-020 resp holds its value from SEND until the next winner is loaded.
REQ-021 req changes while busy=1 have no effect; arbitration occurs only in IDLE.
REQ-022 ptr rotates so a requester that just won has lowest priority next; a lone requester may win consecutively.
REQ-023 Back-to-back spacing: WAIT->IDLE->SEND, i.e. one IDLE cycle minimum between trmt pulses.
REQ-024 gnt bits other than w, and trmt outside SEND, are 0.

Reset
REQ-025 rst=1 forces asynchronously: state=IDLE, ptr=NUM_REQ-1 (req[0] wins the first contention), resp=8'h00, trmt=0, gnt=0, busy=0, timeout=0, timeout counter=0.
REQ-026 rst mid-SEND/WAIT abandons the transaction; no gnt or timeout is issued for it afterwards.

Configuration
REQ-027 Macro RESP_ARB_TIMEOUT_EN defined: 16-bit counter clears on WAIT entry, increments each WAIT cycle; at count TIMEOUT_CYC-1 with tx_done=0, FSM goes IDLE and timeout pulses one cycle in the following cycle; tx_done=1 in that same cycle takes priority (normal exit, no timeout).
REQ-028 Macro undefined: no counter; timeout tied 0; WAIT exits only on tx_done.

Verification
REQ-029 Reset, req=4'b0101, data0=8'hA5, data2=8'h3C -> gnt=4'b0001, trmt, resp=8'hA5; after tx_done -> gnt=4'b0100, resp=8'h3C.
REQ-030 req=4'b1111 held, re-raised after each gnt -> grant order 0,1,2,3,0; exactly one idle cycle between trmt pulses.
REQ-031 tx_done held high from prior byte through SEND -> FSM still enters WAIT; exits only on the tx_done sample in WAIT.
REQ-032 RESP_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, tx_done stuck 0 -> timeout pulse after 16 WAIT cycles, busy drops, next req served; macro undefined -> busy stays high indefinitely.
REQ-033 rst asserted mid-WAIT with req=4'b0010 -> outputs zero immediately; after release, req[1] granted with ptr reset, no timeout pulse.

Source files
------------

// File: rtl/resp_arbiter_if.sv
// Response arbiter bus: requester-side handshake plus the UART wrapper strobe/byte/done.
// The arbiter connects through the slave modport; requesters and the UART wrapper drive master.
interface resp_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   gnt;
   logic                 trmt;
   logic [7:0]           resp;
   logic                 tx_done;
   logic                 busy;
   logic                 timeout;

   modport master (
      output req, req_data, tx_done,
      input  gnt, trmt, resp, busy, timeout
   );

   modport slave (
      input  req, req_data, tx_done,
      output gnt, trmt, resp, busy, timeout
   );
endinterface

// File: rtl/resp_arbiter.sv
// Round-robin arbiter feeding one byte at a time to a UART wrapper (IDLE -> SEND -> WAIT).
// Optional WAIT watchdog enabled by defining RESP_ARB_TIMEOUT_EN.
module resp_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input logic           clk,
   input logic           rst,
   resp_arbiter_if.slave bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [7:0]    resp_q, resp_d;
   logic          timeout_q, timeout_d;
   logic [PW-1:0] win;
   logic          win_vld;
   logic          abort;
   int            pick_idx;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 16'd2) begin : g_bad_cfg
      $error("resp_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
   end

   // Scan from the farthest offset back to ptr+1 so the nearest requester wins last.
   always_comb begin
      win      = ptr_q;
      win_vld  = 1'b0;
      pick_idx = 0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         pick_idx = (int'(ptr_q) + off) % NUM_REQ;
         if (bus.req[pick_idx]) begin
            win     = PW'(pick_idx);
            win_vld = 1'b1;
         end
      end
   end

`ifdef RESP_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SEND) begin
         cnt_d = '0;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign abort = (state_q == WAIT) && !bus.tx_done && (cnt_q == TIMEOUT_CYC - 16'd1);
`else
   assign abort = 1'b0;
`endif

   // tx_done is only looked at in WAIT, so a level left over from the previous byte cannot end SEND.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      resp_d    = resp_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               resp_d  = bus.req_data[8*int'(win) +: 8];
               ptr_d   = win;
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.tx_done) begin
               state_d = IDLE;
            end else if (abort) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= PW'(NUM_REQ - 1);
         resp_q    <= 8'h00;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end

   // ptr_q already holds the winner while in SEND.
   assign bus.trmt    = (state_q == SEND);
   assign bus.gnt     = (state_q == SEND) ? (NUM_REQ'(1) << ptr_q) : '0;
   assign bus.busy    = (state_q != IDLE);
   assign bus.resp    = resp_q;
   assign bus.timeout = timeout_q;

endmodule
